// File: rtl/mask_row_packer.sv
// -----------------------------------------------------------------------------
// mask_row_packer
//
// Packs a serial stream of per-pixel mask bits into 32-bit words, one row at a
// time. A word closes either when 32 bits have been collected or when the last
// pixel of a row arrives, so no word ever spans two rows and any unused upper
// bits of a short word are zero. Closed words go into a 2-entry FIFO towards
// the downstream consumer. The upstream side has no backpressure: if a word
// closes while the FIFO is full and nothing is popped that cycle, the word is
// dropped and the sticky overflow flag is raised, but pixel counting continues.
//
// Parameters
//   image_sensor_w : pixels per row   (1..4095)
//   image_sensor_h : rows per frame   (1..4095)
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset (wins over clk_en)
//   clk_en          in   global clock enable; when low all state is held
//   rp_mask_bit     in   serial mask bit
//   rp_valid        in   rp_mask_bit is valid this cycle
//   word_ready      in   downstream accepts mask_word this cycle
//   mask_word       out  packed word, bit 0 = first pixel of the word
//   word_valid      out  FIFO head is valid
//   word_last_row   out  head word is the last word of its row
//   word_last_frame out  head word is the last word of the frame
//   overflow        out  sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module mask_row_packer #(
  parameter int image_sensor_w = 35,
  parameter int image_sensor_h = 35
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        rp_mask_bit,
  input  logic        rp_valid,
  input  logic        word_ready,
  output logic [31:0] mask_word,
  output logic        word_valid,
  output logic        word_last_row,
  output logic        word_last_frame,
  output logic        overflow
);

  localparam logic [11:0] col_last_c = 12'(image_sensor_w - 1);
  localparam logic [11:0] row_last_c = 12'(image_sensor_h - 1);

  // Assembly state
  logic [31:0] asm_r;
  logic [4:0]  bit_cnt_r;
  logic [11:0] col_r;
  logic [11:0] row_r;

  // FIFO entry layout: {last_frame, last_row, word[31:0]}
  logic [33:0] fifo_r [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic        overflow_r;

  // Per-cycle decode
  logic        accept_s;
  logic        row_end_s;
  logic        frame_end_s;
  logic        word_done_s;
  logic [31:0] word_s;
  logic        pop_s;
  logic        push_s;
  logic        drop_s;

  // Decode of the accept/complete/push/pop/drop conditions for this cycle.
  always_comb begin
    accept_s    = clk_en & rp_valid;
    row_end_s   = (col_r == col_last_c);
    frame_end_s = row_end_s & (row_r == row_last_c);
    word_done_s = accept_s & ((bit_cnt_r == 5'd31) | row_end_s);
    // asm_r is cleared after every completed word, so OR-ing the new bit in
    // leaves all positions above it at zero.
    word_s      = asm_r | ({31'd0, rp_mask_bit} << bit_cnt_r);
    pop_s       = clk_en & (count_r != 2'd0) & word_ready;
    // A pop on the same edge frees a slot even when the FIFO is full.
    push_s      = word_done_s & ((count_r != 2'd2) | pop_s);
    drop_s      = word_done_s & ~push_s;
  end

  // Bit assembly register and intra-word bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r     <= 32'd0;
      bit_cnt_r <= 5'd0;
    end else if (accept_s) begin
      if (word_done_s) begin
        asm_r     <= 32'd0;
        bit_cnt_r <= 5'd0;
      end else begin
        asm_r     <= word_s;
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end
    end else begin
      asm_r     <= asm_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Column/row position of the next pixel; advances even when a word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= 12'd0;
      row_r <= 12'd0;
    end else if (accept_s) begin
      if (row_end_s) begin
        col_r <= 12'd0;
        row_r <= frame_end_s ? 12'd0 : (row_r + 12'd1);
      end else begin
        col_r <= col_r + 12'd1;
        row_r <= row_r;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // FIFO storage and write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_r[i] <= 34'd0;
      end
      wr_ptr_r <= 1'b0;
    end else if (push_s) begin
      fifo_r[wr_ptr_r] <= {frame_end_s, row_end_s, word_s};
      wr_ptr_r         <= ~wr_ptr_r;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // FIFO read pointer and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      rd_ptr_r <= pop_s ? ~rd_ptr_r : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Outputs come straight from the FIFO head registers.
  assign mask_word       = fifo_r[rd_ptr_r][31:0];
  assign word_last_row   = fifo_r[rd_ptr_r][32];
  assign word_last_frame = fifo_r[rd_ptr_r][33];
  assign word_valid      = (count_r != 2'd0);
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_mask_row_packer.sv
// -----------------------------------------------------------------------------
// tb_mask_row_packer
//
// Directed bench for mask_row_packer with W = H = 35. Inputs change #1 after
// each rising edge; outputs are sampled at the same point. Words handed to the
// consumer are captured into got_q just before the edge that pops them.
// -----------------------------------------------------------------------------
module tb_mask_row_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        rp_mask_bit;
  logic        rp_valid;
  logic        word_ready;
  logic [31:0] mask_word;
  logic        word_valid;
  logic        word_last_row;
  logic        word_last_frame;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [33:0] got_q [$];

  mask_row_packer #(
    .image_sensor_w(35),
    .image_sensor_h(35)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .rp_mask_bit    (rp_mask_bit),
    .rp_valid       (rp_valid),
    .word_ready     (word_ready),
    .mask_word      (mask_word),
    .word_valid     (word_valid),
    .word_last_row  (word_last_row),
    .word_last_frame(word_last_frame),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Record a word if it is popped at the coming edge, then advance one cycle.
  task automatic tick();
    if (word_valid === 1'b1 && word_ready === 1'b1 && clk_en === 1'b1 && rst === 1'b0)
      got_q.push_back({word_last_frame, word_last_row, mask_word});
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic b);
    clk_en      = 1'b1;
    rp_valid    = 1'b1;
    rp_mask_bit = b;
    tick();
  endtask

  task automatic idle(input int n);
    rp_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; rp_valid = 1'b0; rp_mask_bit = 1'b0; word_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    check("rst_mask_word", mask_word, 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_last_row", 32'(word_last_row), 32'd0);
    check("rst_last_frame", 32'(word_last_frame), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Full frame of ones, consumer always ready
    word_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 35 * 35; i++) feed(1'b1);
    idle(3);
    check("frame_word_count", 32'(got_q.size()), 32'd70);
    for (int k = 0; k < 70; k++) begin
      check("frame_word", got_q[k][31:0], (k % 2 == 1) ? 32'h0000_0007 : 32'hFFFF_FFFF);
      check("frame_last_row", 32'(got_q[k][32]), (k % 2 == 1) ? 32'd1 : 32'd0);
      check("frame_last_frame", 32'(got_q[k][33]), (k == 69) ? 32'd1 : 32'd0);
    end
    check("frame_overflow", 32'(overflow), 32'd0);

    // Alternating 1,0 starting at col 0 (row 0)
    got_q.delete();
    for (int c = 0; c < 35; c++) feed((c % 2) == 0);
    idle(2);
    check("alt_count", 32'(got_q.size()), 32'd2);
    check("alt_word0", got_q[0][31:0], 32'h5555_5555);
    check("alt_word0_last_row", 32'(got_q[0][32]), 32'd0);
    check("alt_word1", got_q[1][31:0], 32'h0000_0005);
    check("alt_word1_last_row", 32'(got_q[1][32]), 32'd1);
    check("alt_word1_last_frame", 32'(got_q[1][33]), 32'd0);

    // Consumer stalled while 3 words complete (row 1 then row 2)
    word_ready = 1'b0;
    got_q.delete();
    for (int c = 0; c < 32; c++) feed(1'b1);
    check("stall_valid", 32'(word_valid), 32'd1);
    check("stall_head0", mask_word, 32'hFFFF_FFFF);
    feed(1'b0); feed(1'b1); feed(1'b0);
    check("stall_ovf_after2", 32'(overflow), 32'd0);
    check("stall_head_stable", mask_word, 32'hFFFF_FFFF);
    for (int c = 0; c < 31; c++) feed(1'b0);
    check("stall_ovf_before3", 32'(overflow), 32'd0);
    feed(1'b0);
    check("stall_ovf_after3", 32'(overflow), 32'd1);
    check("stall_head_after3", mask_word, 32'hFFFF_FFFF);
    word_ready = 1'b1;
    idle(4);
    check("stall_delivered", 32'(got_q.size()), 32'd2);
    check("stall_word0", got_q[0][31:0], 32'hFFFF_FFFF);
    check("stall_word1", got_q[1][31:0], 32'h0000_0002);
    check("stall_word1_last_row", 32'(got_q[1][32]), 32'd1);
    check("stall_drained", 32'(word_valid), 32'd0);
    check("stall_ovf_sticky", 32'(overflow), 32'd1);
    pulse_reset();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // FIFO full, ready asserted on the cycle a third word completes
    word_ready = 1'b0;
    got_q.delete();
    for (int c = 0; c < 32; c++) feed(1'b1);
    feed(1'b1); feed(1'b1); feed(1'b0);
    for (int c = 0; c < 31; c++) feed(1'b0);
    check("full_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    feed(1'b1);
    check("full_no_drop", 32'(overflow), 32'd0);
    check("full_head_next", mask_word, 32'h0000_0003);
    idle(3);
    check("full_count", 32'(got_q.size()), 32'd3);
    check("full_word0", got_q[0][31:0], 32'hFFFF_FFFF);
    check("full_word1", got_q[1][31:0], 32'h0000_0003);
    check("full_word2", got_q[2][31:0], 32'h8000_0000);
    check("full_ovf_end", 32'(overflow), 32'd0);

    // Reset at col 10 of row 3 with the FIFO holding words and overflow set
    pulse_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 3 * 35 + 10; i++) feed(1'b1);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    rst = 1'b1; clk_en = 1'b1; rp_valid = 1'b1; rp_mask_bit = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_valid", 32'(word_valid), 32'd0);
    check("post_rst_ovf", 32'(overflow), 32'd0);
    check("post_rst_mask", mask_word, 32'h0);
    word_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 32; c++) feed(1'((c >> 1) & 1));
    idle(2);
    check("post_rst_count", 32'(got_q.size()), 32'd1);
    check("post_rst_word", got_q[0][31:0], 32'hCCCC_CCCC);
    check("post_rst_last_row", 32'(got_q[0][32]), 32'd0);

    // clk_en low for 5 cycles mid-row with a word waiting
    word_ready = 1'b0;
    got_q.delete();
    feed(1'b1); feed(1'b1); feed(1'b1);
    for (int c = 0; c < 10; c++) feed(1'b0);
    check("pre_freeze_head", mask_word, 32'h0000_0007);
    clk_en = 1'b0; word_ready = 1'b1; rp_mask_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rp_valid = (i % 2) == 0;
      tick();
      check("freeze_valid", 32'(word_valid), 32'd1);
      check("freeze_head", mask_word, 32'h0000_0007);
      check("freeze_last_row", 32'(word_last_row), 32'd1);
    end
    for (int c = 0; c < 22; c++) feed(1'b1);
    idle(3);
    check("resume_count", 32'(got_q.size()), 32'd2);
    check("resume_word0", got_q[0][31:0], 32'h0000_0007);
    check("resume_word1", got_q[1][31:0], 32'hFFFF_FC00);
    check("resume_word1_last_row", 32'(got_q[1][32]), 32'd0);
    check("resume_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
